mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/arb_hold_counter.sv | 28 ++
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared state encodings and owner codes for the CPU/loader RAM arbiter.
// Optional hold timeout is enabled with MEM_ARB_HOLD_TIMEOUT_EN.
package mem_arbiter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_OWN_CPU = 2'd1;
    localparam logic [1:0] ST_OWN_LDR = 2'd2;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_LDR = 1'b1;

    function automatic logic [1:0] owner_state(input logic owner);
        return (owner == OWNER_CPU) ? ST_OWN_CPU : ST_OWN_LDR;
    endfunction

endpackage

// File: rtl/arb_hold_counter.sv
// Saturating count of granted cycles since the current owner was granted.
// Used by mem_arbiter only when MEM_ARB_HOLD_TIMEOUT_EN is defined.
module arb_hold_counter #(
    parameter int MAX_HOLD = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic at_limit
);

    localparam int CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(MAX_HOLD - 1);

    logic [CW-1:0] cnt;

    assign at_limit = (cnt == LIMIT);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable && !at_limit) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (CPU / program loader) arbiter for a single RAM port.
// Define MEM_ARB_HOLD_TIMEOUT_EN to force hand-over after MAX_HOLD cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_set,
    output logic              ram_get,
    input  logic [DATA_W-1:0] ram_rdata
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       last_owner;
    logic       hold_limit;

`ifdef MEM_ARB_HOLD_TIMEOUT_EN
    arb_hold_counter #(
        .MAX_HOLD(MAX_HOLD)
    ) u_hold (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_nxt != state),
        .enable  (state != ST_IDLE),
        .at_limit(hold_limit)
    );
`else
    assign hold_limit = 1'b0;
    wire unused_hold = (MAX_HOLD != 0);
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (cpu_req && ldr_req) begin
                    state_nxt = owner_state(!last_owner);
                end else if (cpu_req) begin
                    state_nxt = ST_OWN_CPU;
                end else if (ldr_req) begin
                    state_nxt = ST_OWN_LDR;
                end
            end
            ST_OWN_CPU: begin
                if (!cpu_req) begin
                    state_nxt = ldr_req ? ST_OWN_LDR : ST_IDLE;
                end else if (hold_limit && ldr_req) begin
                    state_nxt = ST_OWN_LDR;
                end
            end
            ST_OWN_LDR: begin
                if (!ldr_req) begin
                    state_nxt = cpu_req ? ST_OWN_CPU : ST_IDLE;
                end else if (hold_limit && cpu_req) begin
                    state_nxt = ST_OWN_CPU;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // last_owner starts as LDR so the CPU wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_owner <= OWNER_LDR;
        end else begin
            state <= state_nxt;
            if (state_nxt == ST_OWN_CPU) begin
                last_owner <= OWNER_CPU;
            end else if (state_nxt == ST_OWN_LDR) begin
                last_owner <= OWNER_LDR;
            end
        end
    end

    assign cpu_gnt = (state == ST_OWN_CPU);
    assign ldr_gnt = (state == ST_OWN_LDR);

    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_set   = 1'b0;
        ram_get   = 1'b0;
        cpu_rdata = '0;
        ldr_rdata = '0;
        unique case (1'b1)
            cpu_gnt: begin
                ram_addr  = cpu_addr;
                ram_wdata = cpu_wdata;
                ram_set   = cpu_req & cpu_we;
                ram_get   = cpu_req & ~cpu_we;
                cpu_rdata = ram_rdata;
            end
            ldr_gnt: begin
                ram_addr  = ldr_addr;
                ram_wdata = ldr_wdata;
                ram_set   = ldr_req & ldr_we;
                ram_get   = ldr_req & ~ldr_we;
                ldr_rdata = ram_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a per-cycle ownership model.
// Honours MEM_ARB_HOLD_TIMEOUT_EN the same way the design does.
module tb_mem_arbiter;

    localparam int MAX_HOLD = 4;
`ifdef MEM_ARB_HOLD_TIMEOUT_EN
    localparam bit TIMEOUT = 1'b1;
`else
    localparam bit TIMEOUT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we, ldr_req, ldr_we;
    logic [7:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
    logic       cpu_gnt, ldr_gnt, ram_set, ram_get;
    logic [7:0] cpu_rdata, ldr_rdata, ram_addr, ram_wdata, ram_rdata;

    logic [7:0] mem [0:255];

    int total = 0;
    int bad   = 0;

    // model: 0 = nobody, 1 = cpu, 2 = loader
    int m_own  = 0;
    int m_last = 2;
    int m_held = 0;
    int m_nxt;
    bit m_oreq, m_xreq;
    bit model_live = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W  (8),
        .DATA_W  (8),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_gnt  (cpu_gnt),
        .cpu_rdata(cpu_rdata),
        .ldr_req  (ldr_req),
        .ldr_we   (ldr_we),
        .ldr_addr (ldr_addr),
        .ldr_wdata(ldr_wdata),
        .ldr_gnt  (ldr_gnt),
        .ldr_rdata(ldr_rdata),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_set  (ram_set),
        .ram_get  (ram_get),
        .ram_rdata(ram_rdata)
    );

    assign ram_rdata = mem[ram_addr];

    always @(posedge clk) begin
        if (ram_set) mem[ram_addr] <= ram_wdata;
    end

    always @(posedge clk) begin
        if (reset) begin
            m_own  = 0;
            m_last = 2;
            m_held = 0;
        end else begin
            m_nxt = m_own;
            if (m_own == 0) begin
                if (cpu_req && ldr_req) m_nxt = 3 - m_last;
                else if (cpu_req) m_nxt = 1;
                else if (ldr_req) m_nxt = 2;
            end else begin
                m_oreq = (m_own == 1) ? cpu_req : ldr_req;
                m_xreq = (m_own == 1) ? ldr_req : cpu_req;
                m_held = m_held + 1;
                if (!m_oreq) m_nxt = m_xreq ? 3 - m_own : 0;
                else if (TIMEOUT && m_held >= MAX_HOLD && m_xreq) m_nxt = 3 - m_own;
            end
            if (m_nxt != m_own) begin
                m_held = 0;
                if (m_nxt != 0) m_last = m_nxt;
            end
            m_own = m_nxt;
        end
        model_live = 1'b1;
    end

    logic [35:0] exp_v, act_v;
    logic [7:0]  e_addr, e_wdata;
    logic        e_set, e_get;

    always @(negedge clk) begin
        if (model_live) begin
            e_addr  = 8'h00;
            e_wdata = 8'h00;
            e_set   = 1'b0;
            e_get   = 1'b0;
            if (m_own == 1) begin
                e_addr  = cpu_addr;
                e_wdata = cpu_wdata;
                e_set   = cpu_req && cpu_we;
                e_get   = cpu_req && !cpu_we;
            end else if (m_own == 2) begin
                e_addr  = ldr_addr;
                e_wdata = ldr_wdata;
                e_set   = ldr_req && ldr_we;
                e_get   = ldr_req && !ldr_we;
            end
            exp_v = {m_own == 1, m_own == 2, e_set, e_get, e_addr, e_wdata,
                     (m_own == 1) ? mem[e_addr] : 8'h00,
                     (m_own == 2) ? mem[e_addr] : 8'h00};
            act_v = {cpu_gnt, ldr_gnt, ram_set, ram_get, ram_addr, ram_wdata,
                     cpu_rdata, ldr_rdata};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL cycle_model t=%0t got=%h want=%h", $time, act_v, exp_v);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
        step();
        step();
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_ldr_gnt", ldr_gnt, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_set", ram_set, 0);
        reset = 1'b0;

        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h0F; cpu_wdata = 8'hA5;
        #1;
        chk("lat_pre_gnt", cpu_gnt, 0);
        chk("lat_pre_set", ram_set, 0);
        step();
        chk("wr_cpu_gnt", cpu_gnt, 1);
        chk("wr_ram_set", ram_set, 1);
        chk("wr_ram_addr", ram_addr, 8'h0F);
        chk("wr_ram_wdata", ram_wdata, 8'hA5);
        chk("model_own_cpu", m_own, 1);
        step();
        chk("ram_0f", mem[8'h0F], 8'hA5);
        cpu_req = 0;
        #1;
        chk("drop_set", ram_set, 0);
        chk("drop_gnt_held", cpu_gnt, 1);
        cpu_we = 0;
        step();
        chk("drop_gnt_next", cpu_gnt, 0);

        reset = 1; step(); reset = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h0F;
        ldr_req = 1; ldr_we = 1; ldr_addr = 8'h20; ldr_wdata = 8'h3C;
        step();
        chk("tie_cpu_gnt", cpu_gnt, 1);
        chk("tie_ldr_gnt", ldr_gnt, 0);
        chk("tie_no_ldr_set", ram_set, 0);
        chk("tie_cpu_rdata", cpu_rdata, 8'hA5);
        step();
        cpu_req = 0;
        step();
        chk("handoff_ldr_gnt", ldr_gnt, 1);
        chk("handoff_cpu_gnt", cpu_gnt, 0);
        chk("handoff_addr", ram_addr, 8'h20);
        step();
        chk("ram_20", mem[8'h20], 8'h3C);
        ldr_req = 0;
        cpu_req = 1; cpu_addr = 8'h20;
        step();
        chk("rd_cpu_gnt", cpu_gnt, 1);
        chk("rd_ram_get", ram_get, 1);
        chk("rd_cpu_rdata", cpu_rdata, 8'h3C);
        chk("rd_ldr_rdata", ldr_rdata, 8'h00);

        cpu_req = 0; ldr_we = 0;
        step();
        chk("idle_addr", ram_addr, 0);
        chk("model_idle", m_own, 0);
        cpu_req = 1; cpu_addr = 8'h11;
        step();
        chk("hold_c0", cpu_gnt, 1);
        ldr_req = 1; ldr_addr = 8'h22;
        step(); step(); step();
        chk("hold_c3", cpu_gnt, 1);
        step();
        if (TIMEOUT) begin
            chk("timeout_ldr_gnt", ldr_gnt, 1);
            chk("timeout_cpu_gnt", cpu_gnt, 0);
            ldr_req = 0;
            step();
            chk("regrant_cpu", cpu_gnt, 1);
        end else begin
            chk("no_timeout_cpu", cpu_gnt, 1);
            cpu_req = 0;
            step();
            chk("release_ldr", ldr_gnt, 1);
        end
        cpu_req = 0; ldr_req = 0;
        step();
        chk("idle_again", cpu_gnt | ldr_gnt, 0);

        cpu_req = 1;
        step();
        step(); step(); step(); step(); step();
        ldr_req = 1;
        step();
        chk("sat_handover", TIMEOUT ? ldr_gnt : cpu_gnt, 1);
        cpu_req = 0; ldr_req = 0;
        step();
        step();

        cpu_req = 1; cpu_we = 0;
        step();
        chk("pre_cpu_gnt", cpu_gnt, 1);
        cpu_req = 0;
        step();
        cpu_req = 1;
        ldr_req = 1; ldr_we = 1; ldr_addr = 8'h44; ldr_wdata = 8'h77;
        step();
        chk("tie_after_cpu", ldr_gnt, 1);
        chk("ldr_wr_set", ram_set, 1);
        reset = 1;
        step();
        chk("rst_mid_ldr_gnt", ldr_gnt, 0);
        chk("rst_mid_set", ram_set, 0);
        chk("rst_mid_addr", ram_addr, 0);
        reset = 0;
        step();
        chk("rst_tie_cpu", cpu_gnt, 1);
        chk("model_rst_tie", m_own, 1);
        cpu_req = 0; ldr_req = 0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
